// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: Goldschmidt fpdiv control sequencer (Moore FSM driving the fpdiv muxes and enables)
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     division request, sampled only in IDLE
//   rm_in     rounding mode, captured when start is accepted
//   abort     cancel the running division (present only with FPDIV_CTRL_ABORT_EN)
//   sel_mux4  multiplier operand select
//   sel_mux3  multiplier second-operand select
//   en_a      load enable, fpdiv register A
//   en_b      load enable, fpdiv register B
//   en_rem    remainder/round stage enable
//   rm        latched rounding mode
//   busy      high from IA_A through REM
//   done      one-cycle pulse after REM
// Optional feature macro: FPDIV_CTRL_ABORT_EN
module fpdiv_ctrl #(
    parameter int ITERS = 6,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rm_in,
`ifdef FPDIV_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic [1:0] sel_mux4,
    output logic [1:0] sel_mux3,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic       rm,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, IA_A, IA_B, IT_A, IT_B, REM, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rm_q, rm_d;
    logic             more, kill;

    // counter holds the number of iterations already started
    assign more = cnt_q < CNT_W'(ITERS);

`ifdef FPDIV_CTRL_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rm_d    = rm_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = IA_A;
                cnt_d   = CNT_W'(1);
                rm_d    = rm_in;
            end
            IA_A:       state_d = IA_B;
            IA_B, IT_B: state_d = more ? IT_A : REM;
            IT_A: begin
                state_d = IT_B;
                cnt_d   = cnt_q + 1'b1;
            end
            REM:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
        // abort overrides the normal transition, but only while busy
        if (kill && busy)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rm_q    <= rm_d;
        end
    end

    assign en_a     = state_q == IA_A || state_q == IT_A;
    assign en_b     = state_q == IA_B || state_q == IT_B;
    assign en_rem   = state_q == REM;
    assign busy     = en_a || en_b || en_rem;
    assign done     = state_q == DONE;
    assign rm       = rm_q;
    assign sel_mux4 = state_q == IA_B ? 2'b01 :
                      (state_q == IT_A || state_q == REM) ? 2'b10 :
                      state_q == IT_B ? 2'b11 : 2'b00;
    assign sel_mux3 = (state_q == IT_A || state_q == IT_B) ? 2'b01 :
                      state_q == REM ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: table-driven, directed and randomized bench for fpdiv_ctrl (ITERS=6 and ITERS=1)
module tb_fpdiv_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic rm_in = 1'b0;
    logic ab_w;
`ifdef FPDIV_CTRL_ABORT_EN
    logic abort = 1'b0;
    assign ab_w = abort;
`else
    assign ab_w = 1'b0;
`endif

    logic [1:0] s4_6, s3_6, s4_1, s3_1;
    logic a6, b6, r6, m6, bz6, d6, a1, b1, r1, m1, bz1, d1;
    logic [9:0] o6, o1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpdiv_ctrl #(.ITERS(6), .CNT_W(4)) u6 (
        .clk(clk), .reset(reset), .start(start), .rm_in(rm_in),
`ifdef FPDIV_CTRL_ABORT_EN
        .abort(abort),
`endif
        .sel_mux4(s4_6), .sel_mux3(s3_6), .en_a(a6), .en_b(b6), .en_rem(r6),
        .rm(m6), .busy(bz6), .done(d6)
    );

    fpdiv_ctrl #(.ITERS(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .rm_in(rm_in),
`ifdef FPDIV_CTRL_ABORT_EN
        .abort(abort),
`endif
        .sel_mux4(s4_1), .sel_mux3(s3_1), .en_a(a1), .en_b(b1), .en_rem(r1),
        .rm(m1), .busy(bz1), .done(d1)
    );

    // bundle order: {sel_mux4, sel_mux3, en_a, en_b, en_rem, rm, busy, done}
    assign o6 = {s4_6, s3_6, a6, b6, r6, m6, bz6, d6};
    assign o1 = {s4_1, s3_1, a1, b1, r1, m1, bz1, d1};

    task automatic chk(input string n, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", n, got, exp, $time);
        end
    endtask

    // Reference model: an operation is a phase number 1..2*it+2 (0 = idle).
    int   ph6 = 0, ph1 = 0;
    logic rm6 = 1'b0, rm1 = 1'b0;
    logic mon = 1'b0;

    function automatic int nxt(int p, int it, logic s, logic ab);
        int l = 2 * it;
        if (p == 0) return s ? 1 : 0;
        if (ab && p <= l + 1) return 0;
        return p == l + 2 ? 0 : p + 1;
    endfunction

    function automatic logic [9:0] expo(int p, int it, logic r);
        int l = 2 * it;
        logic [1:0] s4, s3;
        logic a, b, m, bz, dn;
        s4 = 2'd0; s3 = 2'd0; a = 1'b0; b = 1'b0; m = 1'b0; bz = 1'b0; dn = 1'b0;
        if (p >= 1 && p <= l) begin
            bz = 1'b1;
            a  = (p % 2) == 1;
            b  = !a;
            s4 = p == 1 ? 2'd0 : p == 2 ? 2'd1 : a ? 2'd2 : 2'd3;
            s3 = p <= 2 ? 2'd0 : 2'd1;
        end else if (p == l + 1) begin
            bz = 1'b1; m = 1'b1; s4 = 2'd2; s3 = 2'd2;
        end else if (p == l + 2) begin
            dn = 1'b1;
        end
        return {s4, s3, a, b, m, r, bz, dn};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph6 <= 0; ph1 <= 0; rm6 <= 1'b0; rm1 <= 1'b0;
        end else begin
            if (ph6 == 0 && start) rm6 <= rm_in;
            if (ph1 == 0 && start) rm1 <= rm_in;
            ph6 <= nxt(ph6, 6, start, ab_w);
            ph1 <= nxt(ph1, 1, start, ab_w);
        end
    end

    always @(negedge clk) begin
        if (mon) begin
            chk("model_i6", o6, expo(ph6, 6, rm6));
            chk("model_i1", o1, expo(ph1, 1, rm1));
        end
    end

    typedef struct {
        logic       st;
        logic       ri;
        logic [9:0] e6;
        logic [7:0] e1;
    } vec_t;

    localparam logic [9:0] A0 = 10'b00_00_100_1_1_0;
    localparam logic [9:0] B0 = 10'b01_00_010_1_1_0;
    localparam logic [9:0] A1 = 10'b10_01_100_1_1_0;
    localparam logic [9:0] B1 = 10'b11_01_010_1_1_0;
    localparam logic [9:0] RM = 10'b10_10_001_1_1_0;
    localparam logic [9:0] DN = 10'b00_00_000_1_0_1;
    localparam logic [9:0] ID = 10'b00_00_000_1_0_0;
    localparam logic [7:0] XA = 8'b0000_1000;
    localparam logic [7:0] XB = 8'b0100_0100;
    localparam logic [7:0] XR = 8'b1010_0010;
    localparam logic [7:0] XD = 8'b0000_0001;
    localparam logic [7:0] XI = 8'b0000_0000;

    vec_t tv [16];
    int   dcnt;

    initial begin
        tv[0]  = '{1'b1, 1'b1, A0, XA};
        tv[1]  = '{1'b0, 1'b1, B0, XB};
        tv[2]  = '{1'b0, 1'b1, A1, XR};
        tv[3]  = '{1'b0, 1'b1, B1, XD};
        tv[4]  = '{1'b0, 1'b1, A1, XI};
        tv[5]  = '{1'b1, 1'b0, B1, XA};
        tv[6]  = '{1'b0, 1'b0, A1, XB};
        tv[7]  = '{1'b0, 1'b0, B1, XR};
        tv[8]  = '{1'b0, 1'b1, A1, XD};
        tv[9]  = '{1'b0, 1'b0, B1, XI};
        tv[10] = '{1'b0, 1'b0, A1, XI};
        tv[11] = '{1'b0, 1'b0, B1, XI};
        tv[12] = '{1'b0, 1'b0, RM, XI};
        tv[13] = '{1'b0, 1'b0, DN, XI};
        tv[14] = '{1'b0, 1'b0, ID, XI};
        tv[15] = '{1'b0, 1'b0, ID, XI};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_i6", o6, 10'd0);
        chk("reset_i1", o1, 10'd0);
        mon = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);

        // single op with re-pulsed start and rm_in toggling while busy
        for (int i = 0; i < 16; i++) begin
            start = tv[i].st;
            rm_in = tv[i].ri;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec_i6_%0d", i), o6, tv[i].e6);
            chk($sformatf("vec_i1_%0d", i), {2'b00, o1[9:3], o1[0]}, {2'b00, tv[i].e1});
        end

        // start held high: one op every 15 cycles with one IDLE cycle in between
        start = 1'b1;
        dcnt  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (d6) dcnt++;
            if (k == 13 || k == 28) chk($sformatf("b2b_done_%0d", k), {9'd0, d6}, 10'd1);
            if (k == 14 || k == 29) chk($sformatf("b2b_idle_%0d", k), {9'd0, bz6}, 10'd0);
        end
        chk("b2b_done_count", 10'(dcnt), 10'd2);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // reset asserted mid-operation while in IT_A
        start = 1'b1;
        rm_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_abort_ita", o6, A1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_i6", o6, 10'd0);
        chk("async_reset_i1", o1, 10'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (d6) dcnt++;
        end
        chk("no_done_after_reset", 10'(dcnt), 10'd0);

`ifdef FPDIV_CTRL_ABORT_EN
        // abort during cycle 9, restart sampled at edge 12
        for (int k = 0; k < 30; k++) begin
            start = (k == 0 || k == 12);
            abort = (k == 9);
            @(posedge clk);
            @(negedge clk);
            if (k == 9) chk("abort_idle", {6'd0, a6, b6, r6, bz6}, 10'd0);
            if (k == 13) chk("abort_no_done", {9'd0, d6}, 10'd0);
            if (k == 25) chk("abort_restart_done", {9'd0, d6}, 10'd1);
        end
        start = 1'b0;
        abort = 1'b0;
`endif

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom % 3) == 0;
            rm_in = $urandom % 2;
`ifdef FPDIV_CTRL_ABORT_EN
            abort = ($urandom % 16) == 0;
`endif
            if (($urandom % 200) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end

        mon = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Control sequencer for the Goldschmidt fpdiv datapath.
- Generates the per-cycle mux selects and register enables (sel_mux4, sel_mux3, en_a, en_b, en_rem) plus the rounding-mode bit that bench stimulus currently drives by hand.
- Accepts a start/done handshake from the FPU top level and runs one full division: initial-approximation iteration, refinement iterations, then the remainder/rounding cycle.
- Drives fpdiv directly; the fpdiv port list is unchanged.

Parameters:
- ITERS, 6: total Goldschmidt iterations, including the IA iteration. Legal range 1..15.
- CNT_W, 4: width of the iteration counter. Must satisfy 2^CNT_W > ITERS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- rm_in  input  1  rounding mode for this operation; captured when start is accepted.
- sel_mux4  output  2  multiplier operand select to fpdiv.
- sel_mux3  output  2  multiplier second-operand select to fpdiv.
- en_a  output  1  load enable, fpdiv register A.
- en_b  output  1  load enable, fpdiv register B.
- en_rem  output  1  remainder/round stage enable.
- rm  output  1  latched rounding mode to fpdiv.
- busy  output  1  high from IA_A through REM inclusive.
- done  output  1  one-cycle pulse after REM.

Behaviour:
- Reset (async assert): state=IDLE, iteration counter=0, rm=0. All outputs 0.
- Outputs are Moore: registered state decode only. No combinational path from start to any output.
- State encoding, outputs listed as sel_mux4/sel_mux3/en_a/en_b/en_rem:
  - IDLE: 00/00/0/0/0
  - IA_A: 00/00/1/0/0
  - IA_B: 01/00/0/1/0
  - IT_A: 10/01/1/0/0
  - IT_B: 11/01/0/1/0
  - REM: 10/10/0/0/1
  - DONE: 00/00/0/0/0, done=1
- Transitions:
  - IDLE: start=1 -> IA_A. Captures rm<=rm_in and sets counter=1.
  - IA_A -> IA_B.
  - IA_B -> IT_A if counter<ITERS, else REM.
  - IT_A -> IT_B; counter increments on this transition.
  - IT_B -> IT_A if counter<ITERS, else REM.
  - REM -> DONE.
  - DONE -> IDLE, unconditionally.
- Latency: start sampled at edge 0 gives IA_A in cycle 1, REM in cycle 2*ITERS+1, done in cycle 2*ITERS+2.
  - ITERS=6: en_a in cycles 1,3,5,7,9,11; en_b in 2,4,6,8,10,12; en_rem in 13; done in 14.
- en_a, en_b and en_rem are mutually exclusive in every cycle.
- start while busy or in DONE: ignored and not queued. rm_in changes while busy do not affect rm.
- Back-to-back operation: start held high continuously gives one operation every 2*ITERS+3 cycles, with IDLE visited for one cycle between operations.
- ITERS=1: IA_A, IA_B, REM, DONE; the IT states are never entered.
- rm holds its captured value after DONE until the next accepted start.
- Reset asserted mid-operation: immediate return to IDLE with all enables 0. No done pulse for the aborted operation.

Optional Feature:
- Macro: FPDIV_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any busy state: next state is IDLE, enables drop to 0 on the following cycle, and no done pulse is generated.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the normal transition.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- ITERS=6, start pulsed at cycle 0 with rm_in=1 -> sel_mux4 sequence 00,01,10,11,10,11,10,11,10,11,10,11,10 in cycles 1..13. sel_mux3 is 00 in cycles 1-2, 01 in cycles 3-12, 10 in cycle 13. rm=1 from cycle 1. done=1 in cycle 14 only; busy=1 in cycles 1..13.
- start held high for 40 cycles -> done pulses at cycles 14 and 29. IDLE appears in cycles 15 and 30, then IA_A restarts the next operation.
- Reset driven low during cycle 7 (IT_A) -> all outputs 0 immediately, asynchronously. After release, start=0 keeps IDLE; no done pulse ever appears.
- Parameter override ITERS=1 with start -> en_a cycle 1, en_b cycle 2, en_rem cycle 3 (sel_mux4=10, sel_mux3=10), done cycle 4.
- start re-pulsed at cycle 5 with rm_in=0, and rm_in toggled at cycle 8 -> sequence unchanged, rm stays 1, exactly one done at cycle 14.
- With FPDIV_CTRL_ABORT_EN defined, abort=1 at cycle 9 -> cycle 10 is IDLE with all enables 0, and no done in cycle 14. A new start at cycle 12 then produces done at cycle 26.
